// File: rtl/lcd_capture.sv
// lcd_capture: stores the GameBoy LCD pixel stream as a packed 2 bpp frame.
// Strobes are edge-detected after a two-stage input register.
module lcd_capture #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 144,
  parameter int ADDR_W = 13
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        pixel_data,
  input  logic              pixel_clock,
  input  logic              pixel_latch,
  input  logic              hsync,
  input  logic              vsync,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              fb_we,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              line_error
);

  localparam logic [7:0]        X_END = 8'(WIDTH);
  localparam logic [7:0]        Y_END = 8'(HEIGHT);
  localparam logic [ADDR_W-1:0] BPL   = ADDR_W'(WIDTH / 4);

  typedef enum logic [1:0] {
    WAIT,
    ACTIVE,
    HOLD
  } state_t;

  state_t state, state_nxt;

  logic       pclk_s1, pclk_s2;
  logic       plat_s1, plat_s2;
  logic       vs_s1, vs_s2;
  logic [1:0] pd_s1;
  logic       px_stb, ln_stb, vs_stb;

  logic [7:0]        x, x_nxt;
  logic [7:0]        y, y_nxt;
  logic [1:0]        phase, phase_nxt;
  logic [7:0]        sr, sr_nxt;
  logic [1:0]        pad;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        data_nxt;
  logic              we_nxt, done_nxt, err_nxt;
  logic [7:0]        count_nxt;

  // hsync is reserved for a later scan-out mode
  logic unused_hsync;
  assign unused_hsync = hsync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pclk_s1 <= 1'b0;
      pclk_s2 <= 1'b0;
      plat_s1 <= 1'b0;
      plat_s2 <= 1'b0;
      vs_s1   <= 1'b0;
      vs_s2   <= 1'b0;
      pd_s1   <= 2'd0;
    end else begin
      pclk_s1 <= pixel_clock;
      pclk_s2 <= pclk_s1;
      plat_s1 <= pixel_latch;
      plat_s2 <= plat_s1;
      vs_s1   <= vsync;
      vs_s2   <= vs_s1;
      pd_s1   <= pixel_data;
    end
  end

  assign px_stb = pclk_s1 & ~pclk_s2;
  assign ln_stb = plat_s1 & ~plat_s2;
  assign vs_stb = vs_s1 & ~vs_s2;

  assign line_base = ADDR_W'(y) * BPL;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= WAIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    phase_nxt = phase;
    sr_nxt    = sr;
    pad       = 2'd0;
    addr_nxt  = fb_addr;
    data_nxt  = fb_data;
    we_nxt    = 1'b0;
    done_nxt  = 1'b0;
    count_nxt = frame_count;
    err_nxt   = line_error;
    if (vs_stb) begin
      x_nxt     = 8'd0;
      y_nxt     = 8'd0;
      phase_nxt = 2'd0;
      sr_nxt    = 8'd0;
      err_nxt   = 1'b0;
      state_nxt = ACTIVE;
      if (state != WAIT && y == Y_END) begin
        done_nxt  = 1'b1;
        count_nxt = frame_count + 8'd1;
      end
    end else if (state == ACTIVE) begin
      if (px_stb) begin
        if (x < X_END) begin
          sr_nxt = {sr[5:0], pd_s1};
          if (phase == 2'd3) begin
            we_nxt   = 1'b1;
            addr_nxt = line_base + ADDR_W'(x[7:2]);
            data_nxt = sr_nxt;
          end
          x_nxt     = x + 8'd1;
          phase_nxt = phase + 2'd1;
        end else begin
          err_nxt = 1'b1;
        end
      end
      // line end sees the pixel of the same cycle already applied
      if (ln_stb) begin
        if (x_nxt != X_END) err_nxt = 1'b1;
        if (phase_nxt != 2'd0) begin
          pad      = 2'd0 - phase_nxt;
          we_nxt   = 1'b1;
          addr_nxt = line_base + ADDR_W'(x_nxt[7:2]);
          data_nxt = sr_nxt << {pad, 1'b0};
        end
        x_nxt     = 8'd0;
        phase_nxt = 2'd0;
        sr_nxt    = 8'd0;
        y_nxt     = y + 8'd1;
        if (y_nxt == Y_END) state_nxt = HOLD;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x           <= 8'd0;
      y           <= 8'd0;
      phase       <= 2'd0;
      sr          <= 8'd0;
      fb_addr     <= '0;
      fb_data     <= 8'd0;
      fb_we       <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 8'd0;
      line_error  <= 1'b0;
    end else begin
      x           <= x_nxt;
      y           <= y_nxt;
      phase       <= phase_nxt;
      sr          <= sr_nxt;
      fb_addr     <= addr_nxt;
      fb_data     <= data_nxt;
      fb_we       <= we_nxt;
      frame_done  <= done_nxt;
      frame_count <= count_nxt;
      line_error  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_capture.sv
// tb_lcd_capture: scoreboard bench for lcd_capture on a reduced frame size.
// Expected writes are queued as stimulus is driven and popped on fb_we.
module tb_lcd_capture;

  localparam int W   = 32;
  localparam int H   = 12;
  localparam int BPL = W / 4;
  localparam int NB  = W * H / 4;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clock;
  logic        reset;
  logic [1:0]  pixel_data;
  logic        pixel_clock;
  logic        pixel_latch;
  logic        hsync;
  logic        vsync;
  logic [12:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        line_error;

  wr_t        exp_q[$];
  wr_t        got;
  logic [7:0] mem [0:NB-1];
  int         checks = 0;
  int         errors = 0;
  int         wr_count = 0;
  int         done_count = 0;
  int         last_addr = -1;

  lcd_capture #(
    .WIDTH(W),
    .HEIGHT(H),
    .ADDR_W(13)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pixel_data(pixel_data),
    .pixel_clock(pixel_clock),
    .pixel_latch(pixel_latch),
    .hsync(hsync),
    .vsync(vsync),
    .fb_addr(fb_addr),
    .fb_data(fb_data),
    .fb_we(fb_we),
    .frame_done(frame_done),
    .frame_count(frame_count),
    .line_error(line_error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock) begin
    if (!reset && fb_we) begin
      wr_count++;
      last_addr = int'(fb_addr);
      if (int'(fb_addr) < NB) mem[fb_addr] = fb_data;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %h, required no write",
                 fb_addr, fb_data);
      end else begin
        got = exp_q.pop_front();
        if ({fb_addr, fb_data} !== {got.addr, got.data}) begin
          errors++;
          $display("FAIL write: got addr %0d data %h, required addr %0d data %h",
                   fb_addr, fb_data, got.addr, got.data);
        end
      end
    end
    if (!reset && frame_done) done_count++;
  end

  function automatic logic [1:0] pat(input int sel, input int x, input int y);
    if (sel == 0) return 2'(x + y);
    return 2'(x + 2 * y + 1);
  endfunction

  function automatic logic [7:0] pk(input logic [1:0] a, input logic [1:0] b,
                                    input logic [1:0] c, input logic [1:0] d);
    return {a, b, c, d};
  endfunction

  task automatic push(input int a, input logic [7:0] d);
    exp_q.push_back(wr_t'{addr: 13'(a), data: d});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic px(input logic [1:0] d);
    @(negedge clock);
    pixel_data  = d;
    pixel_clock = 1'b1;
    @(negedge clock);
    pixel_clock = 1'b0;
  endtask

  task automatic lat();
    @(negedge clock);
    pixel_latch = 1'b1;
    @(negedge clock);
    pixel_latch = 1'b0;
  endtask

  task automatic vs();
    @(negedge clock);
    vsync = 1'b1;
    @(negedge clock);
    vsync = 1'b0;
  endtask

  task automatic px_lat(input logic [1:0] d);
    @(negedge clock);
    pixel_data  = d;
    pixel_clock = 1'b1;
    pixel_latch = 1'b1;
    @(negedge clock);
    pixel_clock = 1'b0;
    pixel_latch = 1'b0;
  endtask

  task automatic vs_px(input logic [1:0] d);
    @(negedge clock);
    pixel_data  = d;
    pixel_clock = 1'b1;
    vsync       = 1'b1;
    @(negedge clock);
    pixel_clock = 1'b0;
    vsync       = 1'b0;
  endtask

  task automatic pattern_line(input int sel, input int y);
    for (int b = 0; b < BPL; b++)
      push(y * BPL + b, pk(pat(sel, 4*b, y), pat(sel, 4*b+1, y),
                           pat(sel, 4*b+2, y), pat(sel, 4*b+3, y)));
    for (int x = 0; x < W; x++) px(pat(sel, x, y));
    lat();
  endtask

  task automatic drained(input string name);
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending writes, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    int wc;
    idle(3);
    checks += 6;
    if (fb_addr !== 13'd0) begin errors++; $display("FAIL rst_addr: got %0d, required 0", fb_addr); end
    if (fb_data !== 8'd0) begin errors++; $display("FAIL rst_data: got %h, required 00", fb_data); end
    if (fb_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b, required 0", fb_we); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", frame_done); end
    if (frame_count !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d, required 0", frame_count); end
    if (line_error !== 1'b0) begin errors++; $display("FAIL rst_err: got %b, required 0", line_error); end
    reset = 1'b0;
    wc = wr_count;
    for (int i = 0; i < 8; i++) px(2'd3);
    lat();
    idle(4);
    checks++;
    if (wr_count != wc) begin errors++; $display("FAIL wait_ignores: got %0d writes, required 0", wr_count - wc); end
  endtask

  task automatic test_nominal();
    int wc, dc;
    vs();
    wc = wr_count;
    dc = done_count;
    for (int y = 0; y < H; y++) pattern_line(0, y);
    idle(4);
    checks++;
    if (line_error !== 1'b0) begin errors++; $display("FAIL nom_err: got %b, required 0", line_error); end
    vs();
    drained("nominal");
    checks += 5;
    if (wr_count - wc != NB) begin errors++; $display("FAIL nom_writes: got %0d, required %0d", wr_count - wc, NB); end
    if (done_count - dc != 1) begin errors++; $display("FAIL nom_done: got %0d, required 1", done_count - dc); end
    if (frame_count !== 8'd1) begin errors++; $display("FAIL nom_count: got %0d, required 1", frame_count); end
    if (mem[0] !== 8'h1B) begin errors++; $display("FAIL nom_byte0: got %h, required 1b", mem[0]); end
    if (mem[BPL] !== 8'h6C) begin errors++; $display("FAIL nom_byte_line1: got %h, required 6c", mem[BPL]); end
  endtask

  task automatic test_short_line();
    vs();
    for (int b = 0; b < BPL - 1; b++) push(b, 8'hFF);
    push(BPL - 1, 8'hF0);
    for (int x = 0; x < W - 2; x++) px(2'd3);
    lat();
    push(BPL, 8'h55);
    for (int x = 0; x < 4; x++) px(2'd1);
    drained("short");
    checks += 2;
    if (line_error !== 1'b1) begin errors++; $display("FAIL short_err: got %b, required 1", line_error); end
    if (mem[BPL-1] !== 8'hF0) begin errors++; $display("FAIL short_flush: got %h, required f0", mem[BPL-1]); end
    vs();
    idle(3);
    checks++;
    if (line_error !== 1'b0) begin errors++; $display("FAIL short_clear: got %b, required 0", line_error); end
  endtask

  task automatic test_long_line();
    int wc;
    vs();
    for (int y = 0; y < 5; y++) begin
      for (int b = 0; b < BPL; b++) push(y * BPL + b, 8'h00);
      for (int x = 0; x < W; x++) px(2'd0);
      lat();
    end
    drained("long_pre");
    checks++;
    if (line_error !== 1'b0) begin errors++; $display("FAIL long_pre_err: got %b, required 0", line_error); end
    wc = wr_count;
    for (int b = 0; b < BPL; b++) push(5 * BPL + b, 8'hAA);
    for (int x = 0; x < W; x++) px(2'd2);
    px(2'd3);
    px(2'd3);
    lat();
    drained("long");
    checks += 2;
    if (wr_count - wc != BPL) begin errors++; $display("FAIL long_writes: got %0d, required %0d", wr_count - wc, BPL); end
    if (line_error !== 1'b1) begin errors++; $display("FAIL long_err: got %b, required 1", line_error); end
    push(6 * BPL, 8'h55);
    for (int x = 0; x < 4; x++) px(2'd1);
    drained("long_next");
    vs();
  endtask

  task automatic test_simultaneous();
    int wc;
    vs();
    push(0, 8'h6C);
    px(2'd1);
    px(2'd2);
    px(2'd3);
    wc = wr_count;
    px_lat(2'd0);
    drained("simul_pl");
    checks += 2;
    if (wr_count - wc != 1) begin errors++; $display("FAIL simul_pl_writes: got %0d, required 1", wr_count - wc); end
    if (line_error !== 1'b1) begin errors++; $display("FAIL simul_pl_err: got %b, required 1", line_error); end
    push(BPL, 8'hAA);
    for (int x = 0; x < 4; x++) px(2'd2);
    drained("simul_line1");
    px(2'd1);
    wc = wr_count;
    vs_px(2'd3);
    idle(4);
    checks += 2;
    if (wr_count != wc) begin errors++; $display("FAIL simul_vs_writes: got %0d, required 0", wr_count - wc); end
    if (line_error !== 1'b0) begin errors++; $display("FAIL simul_vs_err: got %b, required 0", line_error); end
    push(0, 8'h55);
    for (int x = 0; x < 4; x++) px(2'd1);
    drained("simul_vs");
  endtask

  task automatic test_overflow_lines();
    int wc, dc;
    vs();
    dc = done_count;
    for (int y = 0; y < H - 1; y++) lat();
    for (int b = 0; b < BPL; b++) push((H - 1) * BPL + b, 8'hAA);
    for (int x = 0; x < W; x++) px(2'd2);
    lat();
    drained("ovf_last");
    wc = wr_count;
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < W; x++) px(2'd1);
      lat();
    end
    idle(4);
    checks += 2;
    if (wr_count != wc) begin errors++; $display("FAIL ovf_ignored: got %0d writes, required 0", wr_count - wc); end
    if (last_addr != NB - 1) begin errors++; $display("FAIL ovf_last_addr: got %0d, required %0d", last_addr, NB - 1); end
    vs();
    idle(4);
    checks += 2;
    if (done_count - dc != 1) begin errors++; $display("FAIL ovf_done: got %0d, required 1", done_count - dc); end
    if (frame_count !== 8'd2) begin errors++; $display("FAIL ovf_count: got %0d, required 2", frame_count); end
  endtask

  task automatic test_wrap();
    int dc;
    dc = done_count;
    for (int f = 0; f < 254; f++) begin
      for (int y = 0; y < H; y++) lat();
      vs();
      if (f == 252) begin
        idle(3);
        checks++;
        if (frame_count !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d, required 255", frame_count); end
      end
    end
    idle(3);
    checks += 2;
    if (frame_count !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d, required 0", frame_count); end
    if (done_count - dc != 254) begin errors++; $display("FAIL wrap_done: got %0d, required 254", done_count - dc); end
  endtask

  task automatic test_reset_mid();
    int wc, dc;
    for (int y = 0; y < H; y++) lat();
    vs();
    lat();
    pattern_line(0, 1);
    pattern_line(0, 2);
    for (int b = 0; b < 3; b++)
      push(3 * BPL + b, pk(pat(0, 4*b, 3), pat(0, 4*b+1, 3),
                           pat(0, 4*b+2, 3), pat(0, 4*b+3, 3)));
    for (int x = 0; x < 13; x++) px(pat(0, x, 3));
    drained("mid_pre");
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checks += 4;
    if (fb_addr !== 13'd0) begin errors++; $display("FAIL mid_rst_addr: got %0d, required 0", fb_addr); end
    if (fb_data !== 8'd0) begin errors++; $display("FAIL mid_rst_data: got %h, required 00", fb_data); end
    if (frame_count !== 8'd0) begin errors++; $display("FAIL mid_rst_count: got %0d, required 0", frame_count); end
    if (line_error !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %b, required 0", line_error); end
    @(negedge clock);
    reset = 1'b0;
    wc = wr_count;
    dc = done_count;
    for (int x = 0; x < 8; x++) px(2'd2);
    lat();
    idle(4);
    checks++;
    if (wr_count != wc) begin errors++; $display("FAIL mid_ignored: got %0d writes, required 0", wr_count - wc); end
    vs();
    for (int y = 0; y < H; y++) pattern_line(1, y);
    idle(4);
    checks++;
    if (line_error !== 1'b0) begin errors++; $display("FAIL mid_frame_err: got %b, required 0", line_error); end
    vs();
    drained("mid_frame");
    checks += 3;
    if (done_count - dc != 1) begin errors++; $display("FAIL mid_done: got %0d, required 1", done_count - dc); end
    if (frame_count !== 8'd1) begin errors++; $display("FAIL mid_count: got %0d, required 1", frame_count); end
    if (mem[0] !== 8'h6C) begin errors++; $display("FAIL mid_byte0: got %h, required 6c", mem[0]); end
  endtask

  initial begin
    reset       = 1'b1;
    pixel_data  = 2'd0;
    pixel_clock = 1'b0;
    pixel_latch = 1'b0;
    hsync       = 1'b0;
    vsync       = 1'b0;
    test_reset();
    test_nominal();
    test_short_line();
    test_long_line();
    test_simultaneous();
    test_overflow_lines();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
